fwd_ctrl: RTL
=============

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, the register-index width.
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst_n, input, 1, the reset; synchronous and active-low.
REQ-005 The block SHALL have port id_valid, input, 1, decode stage holds a real instruction.
REQ-006 The block SHALL have ports id_rs1 and id_rs2, input, REG_ADDR_W each, decode-stage source registers.
REQ-007 The block SHALL have port id_rd, input, REG_ADDR_W, decode-stage destination register.
REQ-008 The block SHALL have ports id_regwrite and id_memread, input, 1 each, decode-stage writes-rd / is-load.
REQ-009 The block SHALL have port flush, input, 1, taken branch; kill the decode-stage instruction.
REQ-010 The block SHALL have ports sel_a and sel_b, output, 2 each, selects for the two EX-operand 3-input muxes.
REQ-011 The block SHALL have port stall, output, 1, hold PC and IF/ID this cycle.
REQ-012 The block SHALL have port stall_cnt, output, CNT_W, count of stalled cycles.

Function
REQ-013 The block SHALL hold three shadow stages (EX, MEM, WB), each with valid, rd, regwrite and memread; EX also holds rs1 and rs2.
REQ-014 Each cycle, MEM SHALL load EX and WB SHALL load MEM, unconditionally.
REQ-015 Each cycle, EX SHALL load the id_* inputs when stall=0 and flush=0; otherwise EX SHALL load a bubble (valid=0, regwrite=0, memread=0).
REQ-016 Select encoding SHALL be: SEL_RF=2'b00 (register file), SEL_EXMEM=2'b10 (EX/MEM result), SEL_MEMWB=2'b01 (MEM/WB result); 2'b11 is never driven.
REQ-017 sel_a SHALL be SEL_EXMEM when MEM.valid, MEM.regwrite, MEM.rd!=0 and MEM.rd==EX.rs1.
REQ-018 Otherwise sel_a SHALL be SEL_MEMWB when WB.valid, WB.regwrite, WB.rd!=0 and WB.rd==EX.rs1.
REQ-019 Otherwise sel_a SHALL be SEL_RF.
REQ-020 sel_b SHALL follow REQ-017..019 with EX.rs2; sel_a and sel_b SHALL be combinational from registered state only (zero latency, no input-to-output path).
REQ-021 stall SHALL be 1 iff flush=0, id_valid, EX.valid, EX.memread, EX.rd!=0, and (EX.rd==id_rs1 or EX.rd==id_rs2) (load-use).
REQ-022 stall SHALL be combinational; a given load-use pair SHALL stall exactly one cycle, because the bubble then occupies EX.
REQ-023 flush SHALL take priority over stall: when flush=1, stall=0 and EX loads a bubble.
REQ-024 Register x0 SHALL never cause forwarding or stall.
REQ-025 stall_cnt SHALL increment by 1 on each clock edge where stall=1.
REQ-026 stall_cnt SHALL saturate at all-ones and not wrap.

Reset
REQ-027 When arst_n=0 at a clock edge, all stage valid/regwrite/memread SHALL clear to 0, all rd/rs fields to 0, and stall_cnt to 0.
REQ-028 In the cycle after reset, outputs SHALL be sel_a=sel_b=SEL_RF and stall=0 (given id_valid=0).
REQ-029 Reset asserted mid-operation SHALL discard all in-flight shadow state, with no forwarding from pre-reset instructions.

Structure
REQ-030 SEL_RF, SEL_EXMEM, SEL_MEMWB and a stage-record struct (valid, rd, regwrite, memread) SHALL live in a shared package with the mux select width.
REQ-031 One sub-module, fwd_sel, SHALL compute a single 2-bit select from one source index plus MEM/WB records; it SHALL be instantiated twice (rs1, rs2).

Verification
REQ-032 Bench SHALL cover EX-hazard: add x5 then add x6,x5,x1 on consecutive cycles -> next cycle sel_a=2'b10, sel_b=2'b00.
REQ-033 Bench SHALL cover MEM-hazard with priority: writes x5, x5, then rs1=x5,rs2=x5 -> sel_a=sel_b=2'b10; with one unrelated instruction between -> 2'b01.
REQ-034 Bench SHALL cover load-use: lw x7 then add x8,x7,x2 -> stall=1 for exactly one cycle, stall_cnt 0->1, then sel_a=2'b01.
REQ-035 Bench SHALL cover x0 and flush: lw x0 then use x0 -> stall=0, sels 00; load-use pair with flush=1 -> stall=0 and no forwarding next cycle.
REQ-036 Bench SHALL cover saturation: preload stall_cnt to 16'hFFFE, then 3 stall cycles -> 16'hFFFF held.
REQ-037 Bench SHALL cover mid-run reset: arst_n=0 one edge with MEM/WB holding writes to x3 and rs1=x3 -> sel_a=2'b00 and stall_cnt=0 afterward.

Source files
------------

// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller.
package fwd_ctrl_pkg;

  // Width of a forwarding-mux select.
  localparam int SEL_W = 2;

  // Widest register index the shadow records can hold; narrower indices
  // are zero-extended into the record.
  localparam int RD_W = 8;

  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b01;

  // One shadow pipeline stage.
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } stage_t;

  // True when a stage will write a real (non-x0) register that matches src.
  function automatic logic writes_reg(input stage_t st, input logic [RD_W-1:0] src);
    return st.valid && st.regwrite && (st.rd != '0) && (st.rd == src);
  endfunction

endpackage

// File: rtl/fwd_ctrl_sel.sv
// Single-operand forwarding select: the younger MEM result beats WB.
module fwd_sel
  import fwd_ctrl_pkg::*;
(
  input  logic [RD_W-1:0]  src,
  input  stage_t           mem,
  input  stage_t           wb,
  output logic [SEL_W-1:0] sel
);

  // memread is carried in the record but plays no part in forwarding.
  logic unused_memread;
  assign unused_memread = mem.memread ^ wb.memread;

  // Priority select: MEM over WB over register file.
  always_comb begin
    sel = SEL_RF;
    if (writes_reg(mem, src)) begin
      sel = SEL_EXMEM;
    end else if (writes_reg(wb, src)) begin
      sel = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding-mux selects and load-use stall for a classic 5-stage pipeline.
// Tracks EX/MEM/WB shadow records of in-flight instructions.
// REG_ADDR_W must not exceed fwd_ctrl_pkg::RD_W.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  logic [RD_W-1:0]  ex_rs1_q;
  logic [RD_W-1:0]  ex_rs2_q;
  logic [CNT_W-1:0] cnt_q;
  stage_t           id_rec;
  logic [RD_W-1:0]  id_rs1_w;
  logic [RD_W-1:0]  id_rs2_w;

  assign id_rs1_w = RD_W'(id_rs1);
  assign id_rs2_w = RD_W'(id_rs2);

  // Pack the decode-stage instruction into a stage record.
  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid;
    id_rec.rd       = RD_W'(id_rd);
    id_rec.regwrite = id_regwrite;
    id_rec.memread  = id_memread;
  end

  // Load-use hazard; a flush kills the decode instruction so it cannot stall.
  assign stall = !flush && id_valid && ex_q.valid && ex_q.memread &&
                 (ex_q.rd != '0) &&
                 ((ex_q.rd == id_rs1_w) || (ex_q.rd == id_rs2_w));

  // Advance the shadow pipeline; stalls and flushes inject a bubble into EX.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (!stall && !flush) begin
        ex_q     <= id_rec;
        ex_rs1_q <= id_rs1_w;
        ex_rs2_q <= id_rs2_w;
      end else begin
        ex_q     <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

  fwd_sel u_sel_a (
    .src (ex_rs1_q),
    .mem (mem_q),
    .wb  (wb_q),
    .sel (sel_a)
  );

  fwd_sel u_sel_b (
    .src (ex_rs2_q),
    .mem (mem_q),
    .wb  (wb_q),
    .sel (sel_b)
  );

endmodule
